// File: rtl/packet_gen_mp_pkg.sv
// Shared definitions for the multi-port packet generator.
// Contents: FSM state encoding, header length, MAC OUI prefix,
// metadata field offset helpers and the len -> block-count mapping.
package pkt_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_HDR     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_GAP     = 3'd4
    } state_e;

    localparam int          HDR_WORDS  = 6;
    localparam logic [39:0] MAC_OUI_HI = 40'h02_1B_C5_7E_00;

    // Metadata layout, MSB first: {src, dst, len, time}
    function automatic int unsigned len_lsb(input int unsigned time_w);
        return time_w;
    endfunction

    function automatic int unsigned dst_lsb(input int unsigned time_w, input int unsigned len_w);
        return time_w + len_w;
    endfunction

    function automatic int unsigned src_lsb(input int unsigned time_w, input int unsigned len_w,
                                            input int unsigned port_w);
        return time_w + len_w + port_w;
    endfunction

    // A zero length field encodes the maximum block count.
    function automatic int unsigned len_to_blocks(input int unsigned len, input int unsigned len_w);
        return (len == 0) ? (32'd1 << len_w) : len;
    endfunction

endpackage

// File: rtl/packet_gen_mp_if.sv
// Output stream bus of the packet generator.
// out_data/out_valid/out_sop/out_eop flow master -> slave, out_ready flows back.
interface packet_gen_mp_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;

    modport master (output out_data, output out_valid, output out_sop, output out_eop,
                    input out_ready);
    modport slave  (input out_data, input out_valid, input out_sop, input out_eop,
                    output out_ready);
endinterface

// File: rtl/packet_gen_mp_meta_fifo.sv
// Metadata FIFO: counter-based occupancy over a synchronous-read dual-port RAM.
// simple_dual_port_mem: one write port, one read port with 1-cycle read latency.
// meta_fifo ports: wr_data/wr_en (push), rd_en (pop), rd_data (valid the cycle
// after the pop), full/empty flags, drop_cnt (saturating count of pushes while full).
module simple_dual_port_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

module meta_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [15:0]      drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [15:0]   drop_q;
    logic          wr_ok, rd_ok;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign drop_cnt = drop_q;
    // A push while full is lost even if a pop frees a slot in the same cycle.
    assign wr_ok    = wr_en && !full;
    assign rd_ok    = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (wr_en && full && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
        end
    end

    simple_dual_port_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );
endmodule

// File: rtl/packet_gen_mp.sv
// Packet generator: expands queued metadata entries into framed header+payload
// word streams with valid/ready, SOP/EOP, inter-packet gap and packet count.
// Ports: clk, reset (async active-low); meta_in/meta_in_en push metadata,
// meta_full/meta_drop_cnt report FIFO status; experimenting enables packet
// starts; payload_mode selects all-ones or index payload; gap_cycles idles after
// each EOP; out_if carries the stream; busy = not IDLE; pkt_cnt counts EOP transfers.
//
// state   | meaning
// IDLE    | waiting for run enable and a queued entry; pops on start
// FETCH   | RAM read in flight, metadata register loaded at end of cycle
// HDR     | presenting header words W0..W5
// PAYLOAD | presenting payload words, last one carries EOP
// GAP     | idle countdown after EOP
module packet_gen_mp
    import pkt_gen_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int META_DEPTH  = 1024,
    parameter int LEN_W       = 6,
    parameter int TIME_W      = 22,
    parameter int BLOCK_BYTES = 32,
    localparam int PORT_W     = $clog2(NUM_PORTS),
    localparam int META_W     = 2*PORT_W + LEN_W + TIME_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [META_W-1:0] meta_in,
    input  logic              meta_in_en,
    output logic              meta_full,
    output logic [15:0]       meta_drop_cnt,
    input  logic              experimenting,
    input  logic              payload_mode,
    input  logic [7:0]        gap_cycles,
    packet_gen_mp_if.master   out_if,
    output logic              busy,
    output logic [31:0]       pkt_cnt
);
    localparam logic [2:0] ST_IDLE    = S_IDLE;
    localparam logic [2:0] ST_FETCH   = S_FETCH;
    localparam logic [2:0] ST_HDR     = S_HDR;
    localparam logic [2:0] ST_PAYLOAD = S_PAYLOAD;
    localparam logic [2:0] ST_GAP     = S_GAP;

    localparam int LEN_LSB = int'(len_lsb(TIME_W));
    localparam int DST_LSB = int'(dst_lsb(TIME_W, LEN_W));
    localparam int SRC_LSB = int'(src_lsb(TIME_W, LEN_W, PORT_W));

    logic [2:0]        state_q, state_d;
    logic [META_W-1:0] meta_q, meta_d;
    logic [2:0]        hdr_idx_q, hdr_idx_d;
    logic [15:0]       pay_rem_q, pay_rem_d;
    logic [15:0]       pay_idx_q, pay_idx_d;
    logic              mode_q, mode_d;
    logic [7:0]        gap_q, gap_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;

    logic              pop, fifo_empty, xfer, valid;
    logic [META_W-1:0] fifo_rd_data;
    logic [LEN_W:0]    blk;
    logic [15:0]       len_bytes, words, pay_total;
    logic [7:0]        src_port, dst_port;
    logic [31:0]       hdr_word;

    meta_fifo #(.WIDTH(META_W), .DEPTH(META_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .wr_data  (meta_in),
        .wr_en    (meta_in_en),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .full     (meta_full),
        .empty    (fifo_empty),
        .drop_cnt (meta_drop_cnt)
    );

    assign blk       = (LEN_W+1)'(len_to_blocks(32'(meta_q[LEN_LSB +: LEN_W]), LEN_W));
    assign len_bytes = 16'(32'(blk) * BLOCK_BYTES);
    assign words     = 16'((32'(blk) * BLOCK_BYTES) >> 2);
    assign pay_total = ((words < 16'd8) ? 16'd8 : words) - 16'(HDR_WORDS);
    assign src_port  = 8'(meta_q[SRC_LSB +: PORT_W]);
    assign dst_port  = 8'(meta_q[DST_LSB +: PORT_W]);

    always_comb begin
        hdr_word = '0;
        case (hdr_idx_q)
            3'd0:    hdr_word = {len_bytes, MAC_OUI_HI[39:24]};
            3'd1:    hdr_word = {MAC_OUI_HI[23:0], dst_port};
            3'd2:    hdr_word = 32'(meta_q[TIME_W-1:0]);
            3'd4:    hdr_word = {16'b0, MAC_OUI_HI[39:24]};
            3'd5:    hdr_word = {MAC_OUI_HI[23:0], src_port};
            default: hdr_word = '0;
        endcase
    end

    // Outputs decode straight from held state, so they stay put during stalls
    // and fall to zero the instant reset asserts.
    assign valid            = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);
    assign xfer             = valid && out_if.out_ready;
    assign out_if.out_valid = valid;
    assign out_if.out_sop   = (state_q == ST_HDR) && (hdr_idx_q == 3'd0);
    assign out_if.out_eop   = (state_q == ST_PAYLOAD) && (pay_rem_q == 16'd1);
    assign out_if.out_data  = (state_q == ST_HDR)     ? hdr_word :
                              (state_q == ST_PAYLOAD) ? (mode_q ? 32'(pay_idx_q) : 32'hFFFF_FFFF) :
                                                        32'd0;
    assign busy             = (state_q != ST_IDLE);
    assign pkt_cnt          = pkt_cnt_q;

    always_comb begin
        state_d   = state_q;
        meta_d    = meta_q;
        hdr_idx_d = hdr_idx_q;
        pay_rem_d = pay_rem_q;
        pay_idx_d = pay_idx_q;
        mode_d    = mode_q;
        gap_d     = gap_q;
        pkt_cnt_d = pkt_cnt_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (experimenting && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                meta_d    = fifo_rd_data;
                hdr_idx_d = '0;
                state_d   = ST_HDR;
            end
            ST_HDR: begin
                if (xfer) begin
                    if (hdr_idx_q == 3'd0) mode_d = payload_mode;
                    if (hdr_idx_q == 3'(HDR_WORDS - 1)) begin
                        pay_rem_d = pay_total;
                        pay_idx_d = '0;
                        state_d   = ST_PAYLOAD;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    pay_rem_d = pay_rem_q - 16'd1;
                    pay_idx_d = pay_idx_q + 16'd1;
                    if (pay_rem_q == 16'd1) begin
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                        gap_d     = gap_cycles;
                        state_d   = (gap_cycles != 8'd0) ? ST_GAP : ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q == 8'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            meta_q    <= '0;
            hdr_idx_q <= '0;
            pay_rem_q <= '0;
            pay_idx_q <= '0;
            mode_q    <= 1'b0;
            gap_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            meta_q    <= meta_d;
            hdr_idx_q <= hdr_idx_d;
            pay_rem_q <= pay_rem_d;
            pay_idx_q <= pay_idx_d;
            mode_q    <= mode_d;
            gap_q     <= gap_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
endmodule
